// File: rtl/dds_waveform_generator.sv
// dds_waveform_generator
// Turns the DDS phase accumulator output into a signed audio sample with a
// per-sample choice of sine (quarter-wave LUT), sawtooth, pulse or triangle.
// Three register stages (capture, decode/fold, LUT read + output) give a
// fixed 3-cycle latency at one sample per cycle with no backpressure.
// Optional build macro: WAVE_PHASE_OFFSET_EN adds phase_offset_i, which is
// added (mod 2^WORD_BITS) to phase_i at capture for phase modulation/detune.
module dds_waveform_generator #(
    parameter int WORD_BITS     = 32,
    parameter int SAMPLE_BITS   = 16,
    parameter int LUT_ADDR_BITS = 10
) (
    input  logic                          clk_i,
    input  logic                          n_rst_i,
    input  logic                          enable_i,
    input  logic [WORD_BITS-1:0]          phase_i,
    input  logic [1:0]                    wave_sel_i,
    input  logic [WORD_BITS-1:0]          pulse_width_i,
`ifdef WAVE_PHASE_OFFSET_EN
    input  logic [WORD_BITS-1:0]          phase_offset_i,
`endif
    output logic signed [SAMPLE_BITS-1:0] sample_o,
    output logic                          valid_o
);

    localparam int W         = WORD_BITS;
    localparam int S         = SAMPLE_BITS;
    localparam int L         = LUT_ADDR_BITS;
    localparam int LUT_DEPTH = 1 << L;
    localparam real AMP_R    = real'((1 << (S - 1)) - 1);
    localparam real PI_HALF  = 1.5707963267948966;

    localparam logic [1:0] SEL_SINE  = 2'd0;
    localparam logic [1:0] SEL_SAW   = 2'd1;
    localparam logic [1:0] SEL_PULSE = 2'd2;
    localparam logic [1:0] SEL_TRI   = 2'd3;

    // Symmetric full-scale levels used by the pulse wave.
    localparam logic [S-1:0] POS_FULL = {1'b0, {(S - 1){1'b1}}};
    localparam logic [S-1:0] NEG_FULL = -POS_FULL;

    // Quarter-wave sine magnitudes, sampled at bin centres (k + 0.5) so the
    // table never hits exactly 0 or full scale and folds without a seam.
    // NOTE: this is a constant ROM built at elaboration; it has no state, so
    // it needs no reset and costs nothing to leave unreset.
    logic [S-2:0] lut_rom [LUT_DEPTH];
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam int LUT_VAL =
            int'($floor(AMP_R * $sin(PI_HALF * (real'(k) + 0.5) / real'(LUT_DEPTH)) + 0.5));
        assign lut_rom[k] = LUT_VAL[S-2:0];
    end

    // Effective phase seen by the capture stage.
    logic [W-1:0] phase_in;
`ifdef WAVE_PHASE_OFFSET_EN
    assign phase_in = phase_i + phase_offset_i;
`else
    assign phase_in = phase_i;
`endif

    // Stage 1: captured request.
    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_phase_q, s1_phase_d;
    logic [1:0]   s1_sel_q,   s1_sel_d;
    logic [W-1:0] s1_width_q, s1_width_d;

    // Stage 2: decoded waveform (direct value, or LUT index + sign for sine).
    logic         s2_valid_q,  s2_valid_d;
    logic         s2_sine_q,   s2_sine_d;
    logic         s2_neg_q,    s2_neg_d;
    logic [L-1:0] s2_idx_q,    s2_idx_d;
    logic [S-1:0] s2_direct_q, s2_direct_d;

    // Stage 3: output register.
    logic         valid_q,  valid_d;
    logic [S-1:0] sample_q, sample_d;

    // Decode temporaries.
    logic [1:0]   quad;
    logic [L-1:0] fold_a;
    logic [S-1:0] tri_t;
    logic [S-1:0] lut_mag;

    // S1: capture phase, select and width together so later input changes
    // cannot leak into a sample already in flight.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        s1_valid_d = enable_i;
        s1_phase_d = s1_phase_q;
        s1_sel_d   = s1_sel_q;
        s1_width_d = s1_width_q;
        if (enable_i) begin
            s1_phase_d = phase_in;
            s1_sel_d   = wave_sel_i;
            s1_width_d = pulse_width_i;
        end
    end

    // S2: waveform decode and quarter-wave address fold.
    always_comb begin
        s2_valid_d  = s1_valid_q;
        s2_sine_d   = s2_sine_q;
        s2_neg_d    = s2_neg_q;
        s2_idx_d    = s2_idx_q;
        s2_direct_d = s2_direct_q;
        quad        = s1_phase_q[W-1 -: 2];
        fold_a      = s1_phase_q[W-3 -: L];
        tri_t       = s1_phase_q[W-2 -: S];
        if (s1_phase_q[W-1]) begin
            tri_t = ~tri_t;
        end
        if (s1_valid_q) begin
            s2_sine_d = (s1_sel_q == SEL_SINE);
            s2_neg_d  = quad[1];
            // Odd quadrants run the table backwards: 2^L-1-a == ~a.
            s2_idx_d  = quad[0] ? ~fold_a : fold_a;
            case (s1_sel_q)
                SEL_SAW:   s2_direct_d = {~s1_phase_q[W-1], s1_phase_q[W-2 -: S-1]};
                SEL_PULSE: s2_direct_d = (s1_phase_q < s1_width_q) ? POS_FULL : NEG_FULL;
                SEL_TRI:   s2_direct_d = {~tri_t[S-1], tri_t[S-2:0]};
                default:   s2_direct_d = '0;
            endcase
        end
    end

    // S3: LUT read, sign apply; the output holds between valid samples.
    always_comb begin
        valid_d  = s2_valid_q;
        sample_d = sample_q;
        lut_mag  = {1'b0, lut_rom[s2_idx_q]};
        if (s2_valid_q) begin
            // LUT range is symmetric, so negation cannot overflow.
            sample_d = s2_sine_q ? (s2_neg_q ? -lut_mag : lut_mag) : s2_direct_q;
        end
    end

    // Pipeline registers; reset clears every valid flag and data register,
    // which also drops any samples in flight.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_phase_q  <= '0;
            s1_sel_q    <= '0;
            s1_width_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_sine_q   <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_idx_q    <= '0;
            s2_direct_q <= '0;
            valid_q     <= 1'b0;
            sample_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the
            // previous stage's pre-edge value, independent of statement order.
            s1_valid_q  <= s1_valid_d;
            s1_phase_q  <= s1_phase_d;
            s1_sel_q    <= s1_sel_d;
            s1_width_q  <= s1_width_d;
            s2_valid_q  <= s2_valid_d;
            s2_sine_q   <= s2_sine_d;
            s2_neg_q    <= s2_neg_d;
            s2_idx_q    <= s2_idx_d;
            s2_direct_q <= s2_direct_d;
            valid_q     <= valid_d;
            sample_q    <= sample_d;
        end
    end

    assign sample_o = sample_q;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_dds_waveform_generator.sv
// Self-checking bench for dds_waveform_generator: a table of directed
// vectors streamed back-to-back, plus hand-written sequences for reset,
// output hold, input isolation and (when WAVE_PHASE_OFFSET_EN is defined)
// the phase offset path.
module tb_dds_waveform_generator;

    localparam int W = 32;
    localparam int S = 16;

    logic                clk_i         = 1'b0;
    logic                n_rst_i       = 1'b0;
    logic                enable_i      = 1'b0;
    logic [W-1:0]        phase_i       = '0;
    logic [1:0]          wave_sel_i    = '0;
    logic [W-1:0]        pulse_width_i = '0;
`ifdef WAVE_PHASE_OFFSET_EN
    logic [W-1:0]        phase_offset_i = '0;
`endif
    logic signed [S-1:0] sample_o;
    logic                valid_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    dds_waveform_generator #(
        .WORD_BITS     (W),
        .SAMPLE_BITS   (S),
        .LUT_ADDR_BITS (10)
    ) dut (
        .clk_i         (clk_i),
        .n_rst_i       (n_rst_i),
        .enable_i      (enable_i),
        .phase_i       (phase_i),
        .wave_sel_i    (wave_sel_i),
        .pulse_width_i (pulse_width_i),
`ifdef WAVE_PHASE_OFFSET_EN
        .phase_offset_i(phase_offset_i),
`endif
        .sample_o      (sample_o),
        .valid_o       (valid_o)
    );

    typedef struct {
        string        name;
        logic [1:0]   sel;
        logic [W-1:0] phase;
        logic [W-1:0] width;
        int           exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic add_vec(input string name, input logic [1:0] sel,
                           input logic [W-1:0] phase, input logic [W-1:0] width,
                           input int exp);
        vec_t v;
        v.name  = name;
        v.sel   = sel;
        v.phase = phase;
        v.width = width;
        v.exp   = exp;
        vecs.push_back(v);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] sel,
                         input logic [W-1:0] phase, input logic [W-1:0] width);
        enable_i      = en;
        wave_sel_i    = sel;
        phase_i       = phase;
        pulse_width_i = width;
    endtask

    // Watchdog: the run is a few hundred cycles; anything far beyond is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int n;

        // Reset state.
        repeat (2) step();
        check("reset_sample", int'(sample_o), 0);
        check("reset_valid", int'(valid_o), 0);
        n_rst_i = 1'b1;
        step();
        check("idle_valid", int'(valid_o), 0);

        // Directed vectors, hand-computed.
        add_vec("sine_q0",       2'd0, 32'h0000_0000, 32'h0,          25);
        add_vec("sine_q1",       2'd0, 32'h4000_0000, 32'h0,          32767);
        add_vec("sine_q2",       2'd0, 32'h8000_0000, 32'h0,          -25);
        add_vec("sine_q3",       2'd0, 32'hC000_0000, 32'h0,          -32767);
        add_vec("saw_min",       2'd1, 32'h0000_0000, 32'h0,          -32768);
        add_vec("saw_quarter",   2'd1, 32'h4000_0000, 32'h0,          -16384);
        add_vec("saw_mid",       2'd1, 32'h8000_0000, 32'h0,          0);
        add_vec("saw_max",       2'd1, 32'hFFFF_FFFF, 32'h0,          32767);
        add_vec("pulse_below",   2'd2, 32'h7FFF_FFFF, 32'h8000_0000,  32767);
        add_vec("pulse_at",      2'd2, 32'h8000_0000, 32'h8000_0000,  -32767);
        add_vec("pulse_w0_p0",   2'd2, 32'h0000_0000, 32'h0000_0000,  -32767);
        add_vec("pulse_w0_pmid", 2'd2, 32'h7FFF_FFFF, 32'h0000_0000,  -32767);
        add_vec("pulse_w0_pmax", 2'd2, 32'hFFFF_FFFF, 32'h0000_0000,  -32767);
        add_vec("pulse_wmax_lo", 2'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,  32767);
        add_vec("pulse_wmax_hi", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  -32767);
        add_vec("tri_min",       2'd3, 32'h0000_0000, 32'h0,          -32768);
        add_vec("tri_mid_rise",  2'd3, 32'h4000_0000, 32'h0,          0);
        add_vec("tri_mid_fall",  2'd3, 32'hC000_0000, 32'h0,          -1);
        add_vec("tri_wrap_end",  2'd3, 32'hFFFF_FFFF, 32'h0,          -32768);
        add_vec("tri_max",       2'd3, 32'h8000_0000, 32'h0,          32767);

        // Stream back-to-back; vector s-2 appears after the step of iteration s
        // (enable in cycle c -> valid_o in cycle c+3).
        n = vecs.size();
        for (int s = 0; s < n + 2; s++) begin
            if (s < n) drive(1'b1, vecs[s].sel, vecs[s].phase, vecs[s].width);
            else       drive(1'b0, 2'd0, 32'h1234_5678, 32'h0);
            step();
            if (s >= 2) begin
                check({vecs[s-2].name, "_valid"}, int'(valid_o), 1);
                check(vecs[s-2].name, int'(sample_o), vecs[s-2].exp);
            end else begin
                check("pre_latency_valid", int'(valid_o), 0);
            end
        end

        // Output holds its last value while no new sample arrives.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd1, 32'h9999_0000, 32'h0);
            step();
            check("hold_valid", int'(valid_o), 0);
            check("hold_sample", int'(sample_o), vecs[n-1].exp);
        end

        // Input isolation: sine request, then wave_sel/phase change the next
        // cycle, then a saw request.
        drive(1'b1, 2'd0, 32'h4000_0000, 32'h0);
        step();
        drive(1'b0, 2'd1, 32'h0000_0000, 32'h0);
        step();
        drive(1'b1, 2'd1, 32'h4000_0000, 32'h0);
        step();
        check("isolation_first_valid", int'(valid_o), 1);
        check("isolation_first_sine", int'(sample_o), 32767);
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        check("isolation_gap_valid", int'(valid_o), 0);
        step();
        check("isolation_second_valid", int'(valid_o), 1);
        check("isolation_second_saw", int'(sample_o), -16384);

        // Reset mid-stream with enable_i held high.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0);
            step();
        end
        check("prereset_sample", int'(sample_o), 32767);
        check("prereset_valid", int'(valid_o), 1);
        #3;
        n_rst_i = 1'b0;
        #1;
        check("async_reset_sample", int'(sample_o), 0);
        check("async_reset_valid", int'(valid_o), 0);
        step();
        step();
        check("reset_held_valid", int'(valid_o), 0);
        drive(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0);
        n_rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_release_valid", int'(valid_o), 0);
            check("post_release_sample", int'(sample_o), 0);
        end

        // Fresh request after reset arrives after exactly 3 cycles.
        drive(1'b1, 2'd1, 32'h0000_0000, 32'h0);
        step();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        check("post_reset_lat2_valid", int'(valid_o), 0);
        step();
        check("post_reset_lat3_valid", int'(valid_o), 1);
        check("post_reset_saw", int'(sample_o), -32768);

`ifdef WAVE_PHASE_OFFSET_EN
        // Offset wraps 0x40000000 + 0xC0000000 to phase 0.
        phase_offset_i = 32'hC000_0000;
        drive(1'b1, 2'd0, 32'h4000_0000, 32'h0);
        step();
        drive(1'b0, 2'd0, 32'h0, 32'h0);
        step();
        step();
        check("offset_wrap_valid", int'(valid_o), 1);
        check("offset_wrap_sine", int'(sample_o), 25);
        phase_offset_i = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
